// File: rtl/div_arbiter_if.sv
// Requester/response bundle for div_arbiter.
// master modport: the requester/consumer side. slave modport: the arbiter.
interface div_arbiter_if #(
    parameter int M    = 26,
    parameter int N    = 14,
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_dividend;
    logic [NREQ*N-1:0] req_divisor;
    logic              resp_valid;
    logic [IW-1:0]     resp_id;
    logic [M-1:0]      resp_quotient;
    logic              resp_dz;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, resp_valid, resp_id, resp_quotient, resp_dz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, resp_valid, resp_id, resp_quotient, resp_dz
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined divider among NREQ
// requesters. One division accepted per cycle; each in-flight operation is
// tracked by a {valid, id[, dz]} tag that travels alongside the divider
// latency, so quotients come back in issue order tagged with their owner.
// Optional feature macro: DIV_ARB_ZERO_CHECK_EN (zero-divisor detection,
// forcing an all-ones quotient and raising resp_dz).
module div_arbiter #(
    parameter int M    = 26,
    parameter int N    = 14,
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    div_arbiter_if.slave    bus,
    output logic [M-1:0]    div_dividend,
    output logic [N-1:0]    div_divisor,
    input  logic [M-1:0]    div_quotient,
    output logic            busy
);

    logic [IW-1:0]  ptr_q;
    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]  grant_id_s;
    logic [IW-1:0]  idx_s;
    logic           found_s;
    logic           hs_s;
    logic           dz_s;
    logic [M-1:0]   dividend_q;
    logic [N-1:0]   divisor_q;
    logic           tag_v_q  [LAT+1];
    logic [IW-1:0]  tag_id_q [LAT+1];
    logic           resp_valid_q;
    logic [IW-1:0]  resp_id_q;
    logic [M-1:0]   resp_quotient_q;
    logic           busy_s;
`ifdef DIV_ARB_ZERO_CHECK_EN
    logic           tag_dz_q [LAT+1];
    logic           resp_dz_q;
`endif

    // Round-robin pick: first valid requester at or after ptr+1, none during reset.
    always_comb begin
        grant_s    = {NREQ{1'b0}};
        grant_id_s = {IW{1'b0}};
        idx_s      = {IW{1'b0}};
        found_s    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = IW'((int'(ptr_q) + k) % NREQ);
            if (!found_s && bus.req_valid[idx_s]) begin
                found_s    = 1'b1;
                grant_id_s = idx_s;
            end else begin
                found_s    = found_s;
            end
        end
        if (found_s && !rst) begin
            grant_s[grant_id_s] = 1'b1;
        end else begin
            grant_s = {NREQ{1'b0}};
        end
    end

    assign bus.req_ready = grant_s;
    assign hs_s          = |(bus.req_valid & grant_s);

`ifdef DIV_ARB_ZERO_CHECK_EN
    assign dz_s = (bus.req_divisor[grant_id_s*N +: N] == {N{1'b0}});
`else
    assign dz_s = 1'b0;
`endif

    // Last-granted pointer; reset makes requester 0 the highest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IW'(NREQ - 1);
        end else if (hs_s) begin
            ptr_q <= grant_id_s;
        end
    end

    // Capture the granted operands for the divider; hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_q <= {M{1'b0}};
            divisor_q  <= {N{1'b0}};
        end else if (hs_s) begin
            dividend_q <= bus.req_dividend[grant_id_s*M +: M];
            divisor_q  <= bus.req_divisor[grant_id_s*N +: N];
        end
    end

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

    // Tag shift register matching the divider latency; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LAT; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_id_q[s] <= {IW{1'b0}};
`ifdef DIV_ARB_ZERO_CHECK_EN
                tag_dz_q[s] <= 1'b0;
`endif
            end
        end else begin
            tag_v_q[0]  <= hs_s;
            tag_id_q[0] <= grant_id_s;
`ifdef DIV_ARB_ZERO_CHECK_EN
            tag_dz_q[0] <= hs_s & dz_s;
`endif
            for (int s = 1; s <= LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
`ifdef DIV_ARB_ZERO_CHECK_EN
                tag_dz_q[s] <= tag_dz_q[s-1];
`endif
            end
        end
    end

    // Response register: strobe/id every cycle, quotient only when the last tag is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q    <= 1'b0;
            resp_id_q       <= {IW{1'b0}};
            resp_quotient_q <= {M{1'b0}};
`ifdef DIV_ARB_ZERO_CHECK_EN
            resp_dz_q       <= 1'b0;
`endif
        end else begin
            resp_valid_q <= tag_v_q[LAT];
            resp_id_q    <= tag_id_q[LAT];
`ifdef DIV_ARB_ZERO_CHECK_EN
            resp_dz_q    <= tag_v_q[LAT] & tag_dz_q[LAT];
            if (tag_v_q[LAT] && tag_dz_q[LAT]) begin
                resp_quotient_q <= {M{1'b1}};
            end else if (tag_v_q[LAT]) begin
                resp_quotient_q <= div_quotient;
            end
`else
            if (tag_v_q[LAT]) begin
                resp_quotient_q <= div_quotient;
            end
`endif
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_quotient = resp_quotient_q;
`ifdef DIV_ARB_ZERO_CHECK_EN
    assign bus.resp_dz       = resp_dz_q;
`else
    assign bus.resp_dz       = 1'b0;
`endif

    // Busy whenever any tag stage holds a live operation.
    always_comb begin
        busy_s = 1'b0;
        for (int s = 0; s <= LAT; s++) begin
            busy_s = busy_s | tag_v_q[s];
        end
    end

    assign busy = busy_s;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: a stimulus process predicts grants and
// quotients from the arbitration rules and pushes expected responses with
// their due cycle; a monitor process pops and compares on every cycle.
module tb_div_arbiter;
    localparam int M    = 26;
    localparam int N    = 14;
    localparam int NREQ = 4;
    localparam int LAT  = 1;
    localparam int IW   = $clog2(NREQ);

    typedef struct {
        int            due;
        logic [IW-1:0] id;
        logic [M-1:0]  q;
        logic          dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [M-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic [M-1:0] div_quotient;
    logic         busy;

    div_arbiter_if #(.M(M), .N(N), .NREQ(NREQ), .IW(IW)) bus ();

    div_arbiter #(.M(M), .N(N), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural divider with one cycle of latency.
    always @(posedge clk)
        div_quotient <= (div_divisor == '0) ? '0 : div_dividend / M'(div_divisor);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   started  = 1'b0;
    bit   done     = 1'b0;

    // stimulus-side model
    int           m_ptr;
    logic [M-1:0] m_dd;
    logic [N-1:0] m_dv;
    int           wait_c [NREQ];
    int           max_wait;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ*M-1:0] dd, input logic [NREQ*N-1:0] dv);
        int g;
        logic [M-1:0] a;
        logic [N-1:0] b;
        exp_t e;
        rst = r;
        bus.req_valid    = v;
        bus.req_dividend = dd;
        bus.req_divisor  = dv;
        @(negedge clk);
        g = r ? -1 : exp_grant(v, m_ptr);
        chk("req_ready", longint'(bus.req_ready), (g < 0) ? 0 : (longint'(1) << g));
        if (started) begin
            chk("div_dividend", longint'(div_dividend), longint'(m_dd));
            chk("div_divisor", longint'(div_divisor), longint'(m_dv));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && !r && g != i) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > max_wait) max_wait = wait_c[i];
        end
        if (g >= 0) begin
            a = dd[g*M +: M];
            b = dv[g*N +: N];
            e.due = cyc + LAT + 2;
            e.id  = IW'(g);
            e.q   = (b == '0) ? '0 : a / M'(b);
            e.dz  = 1'b0;
`ifdef DIV_ARB_ZERO_CHECK_EN
            if (b == '0) begin
                e.q  = '1;
                e.dz = 1'b1;
            end
`endif
            sbq.push_back(e);
            m_ptr = g;
            m_dd  = a;
            m_dv  = b;
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_ptr = NREQ - 1;
            m_dd  = '0;
            m_dv  = '0;
        end
    endtask

    // Monitor: compare every presented response against the scoreboard head.
    initial begin
        logic [M-1:0] m_lastq;
        exp_t e;
        bit   exp_busy;
        m_lastq = '0;
        forever begin
            @(negedge clk);
            if (started && !done) begin
                exp_busy = 1'b0;
                foreach (sbq[i])
                    if (sbq[i].due - LAT - 1 <= cyc && cyc <= sbq[i].due - 1) exp_busy = 1'b1;
                chk("busy", longint'(busy), longint'(exp_busy));
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    e = sbq.pop_front();
                    chk("resp_valid", longint'(bus.resp_valid), 1);
                    chk("resp_id", longint'(bus.resp_id), longint'(e.id));
                    chk("resp_quotient", longint'(bus.resp_quotient), longint'(e.q));
                    chk("resp_dz", longint'(bus.resp_dz), longint'(e.dz));
                    m_lastq = e.q;
                end else begin
                    chk("resp_valid_idle", longint'(bus.resp_valid), 0);
                    chk("resp_quotient_hold", longint'(bus.resp_quotient), longint'(m_lastq));
                end
                if (rst) begin
                    m_lastq = '0;
                    for (int i = sbq.size() - 1; i >= 0; i--)
                        if (sbq[i].due > cyc) sbq.delete(i);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [NREQ*M-1:0] dd;
        logic [NREQ*N-1:0] dv;
        logic [NREQ-1:0]   v;
        m_ptr = NREQ - 1;
        m_dd  = '0;
        m_dv  = '0;
        max_wait = 0;
        foreach (wait_c[i]) wait_c[i] = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;

        // reset, with requests asserted to confirm grants are suppressed
        step(1'b1, 4'b1111, '0, '0);
        step(1'b1, 4'b0101, '0, '0);
        started = 1'b1;
        chk("reset_resp_id", longint'(bus.resp_id), 0);
        chk("reset_resp_dz", longint'(bus.resp_dz), 0);
        chk("reset_busy", longint'(busy), 0);

        // single request from requester 1
        dd = '0; dv = '0;
        dd[1*M +: M] = 26'h1FFC000;
        dv[1*N +: N] = 14'd3;
        step(1'b0, 4'b0010, dd, dv);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, dd, dv);

        // contention: all four valid, distinct operands
        for (int i = 0; i < NREQ; i++) begin
            dd[i*M +: M] = M'(1000 * (i + 1) + 7);
            dv[i*N +: N] = N'(i + 2);
        end
        for (int i = 0; i < NREQ; i++) step(1'b0, 4'b1111, dd, dv);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, dd, dv);

        // fairness: requesters 0 and 2 held for 10 cycles
        max_wait = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0101, dd, dv);
        chk("fair_wait_le_1", longint'(max_wait <= 1), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, dd, dv);

        // divide by zero from requester 0
        dd[0*M +: M] = 26'd100;
        dv[0*N +: N] = 14'd0;
        step(1'b0, 4'b0001, dd, dv);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, dd, dv);

        // reset with two operations in flight, then 0 vs 3 contention
        dv[0*N +: N] = 14'd5;
        step(1'b0, 4'b0110, dd, dv);
        step(1'b0, 4'b0110, dd, dv);
        step(1'b1, 4'b1001, dd, dv);
        chk("busy_after_reset", longint'(busy), 0);
        step(1'b0, 4'b1001, dd, dv);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, dd, dv);

        // idle hold
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, dd, dv);

        // randomized traffic with occasional zero divisors and resets
        max_wait = 0;
        for (int t = 0; t < 400; t++) begin
            v = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                dd[i*M +: M] = M'($urandom);
                dv[i*N +: N] = ($urandom_range(7, 0) == 0) ? '0 : N'($urandom);
            end
            step(($urandom_range(63, 0) == 0), v, dd, dv);
        end
        chk("max_wait_le_nreq_minus_1", longint'(max_wait <= NREQ - 1), 1);

        // drain with a bounded budget
        for (int i = 0; i < 20 && sbq.size() > 0; i++) step(1'b0, 4'b0000, dd, dv);
        step(1'b0, 4'b0000, dd, dv);
        chk("drain_empty", longint'(sbq.size()), 0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
